// File: rtl/reg_file_32x32_if.sv
// Register-file access bundle: two read ports, one write port and the write counter.
// Handshake: none; reads are combinational and a write commits on every rising edge with wr_en=1.
interface reg_file_32x32_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        rd_addr_a;
  logic [4:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       wr_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, wr_count
  );
endinterface

// File: rtl/reg_file_32x32.sv
// 32 x DATA_W architectural register file: r0 hardwired to zero, stack pointer reset value,
// two combinational read ports with same-cycle write-through bypass, committed-write counter.
module reg_file_32x32 #(
  parameter int                DATA_W   = 32,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 'h0000_0FFC
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_32x32_if.slave bus
);

  logic [DATA_W-1:0] r_regs [1:31];
  logic [15:0]       r_wr_count;

  logic [DATA_W-1:0] w_regs [0:31];
  logic              w_wr_hit;
  logic              w_byp_a;
  logic              w_byp_b;

  // An X address with wr_en=0 cannot reach storage because wr_en gates every update.
  assign w_wr_hit = bus.wr_en && (bus.wr_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_hit) begin
      for (int i = 1; i < 32; i++) begin
        if (bus.wr_addr == 5'(i)) begin
          r_regs[i] <= bus.wr_data;
        end
      end
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < 32; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  // Bypass is suppressed while reset is held so the ports show reset contents.
  assign w_byp_a = rst_n && w_wr_hit && (bus.wr_addr == bus.rd_addr_a);
  assign w_byp_b = rst_n && w_wr_hit && (bus.wr_addr == bus.rd_addr_b);

  assign bus.rd_data_a = w_byp_a ? bus.wr_data : w_regs[bus.rd_addr_a];
  assign bus.rd_data_b = w_byp_b ? bus.wr_data : w_regs[bus.rd_addr_b];
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: reset contents, r0, full write/readback, bypass,
// enable gating, back-to-back writes, counter wrap and reset during a write.
module tb_reg_file_32x32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [31:0] exp_regs [0:31];
  logic [15:0] exp_cnt;

  reg_file_32x32_if #(.DATA_W(32)) bus ();

  reg_file_32x32 #(
    .DATA_W  (32),
    .SP_IDX  (29),
    .SP_RESET(32'h0000_0FFC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    exp_regs[29] = 32'h0000_0FFC;
    exp_cnt = 16'h0;
  endtask

  // Reads every address on both ports (port B walks in reverse); caller keeps wr_en=0.
  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      #1;
      check($sformatf("%s_a_r%0d", tag, i), bus.rd_data_a, exp_regs[i]);
      check($sformatf("%s_b_r%0d", tag, 31 - i), bus.rd_data_b, exp_regs[31 - i]);
    end
  endtask

  // Driver: one write committed on the next rising edge.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    if (addr != 5'd0) begin
      exp_regs[addr] = data;
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  initial begin
    int n;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b1;
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'h0;
    model_reset();

    // Reset pulsed mid-cycle: outputs follow without a clock edge
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.rd_addr_a = 5'd29;
    #1;
    check("async_rst_sp", bus.rd_data_a, 32'h0000_0FFC);
    check("async_rst_cnt", {16'h0, bus.wr_count}, 32'h0);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd29;
    bus.wr_data   = 32'h1111_1111;
    bus.rd_addr_b = 5'd29;
    #1;
    check("rst_no_bypass_a", bus.rd_data_a, 32'h0000_0FFC);
    check("rst_no_bypass_b", bus.rd_data_b, 32'h0000_0FFC);
    bus.wr_en = 1'b0;
    check_all("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_rst");
    check("post_rst_cnt", {16'h0, bus.wr_count}, 32'h0);

    // r0 protection, including the bypass path
    @(negedge clk);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'hDEAD_BEEF;
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd0;
    #1;
    check("r0_bypass_a", bus.rd_data_a, 32'h0);
    check("r0_bypass_b", bus.rd_data_b, 32'h0);
    write_reg(5'd0, 32'hDEAD_BEEF);
    check("r0_read", bus.rd_data_a, 32'h0);
    check("r0_cnt", {16'h0, bus.wr_count}, 32'h0);

    // Write r1..r31 then read back
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A5_0000 | 32'(i));
    check("wall_cnt", {16'h0, bus.wr_count}, 32'd31);
    check_all("wall");

    // Bypass on the link register from both ports, then storage after the edge
    @(negedge clk);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd31;
    bus.wr_data   = 32'h0000_0040;
    bus.rd_addr_a = 5'd31;
    bus.rd_addr_b = 5'd31;
    #1;
    check("byp_a", bus.rd_data_a, 32'h0000_0040);
    check("byp_b", bus.rd_data_b, 32'h0000_0040);
    bus.rd_addr_b = 5'd30;
    #1;
    check("byp_indep_b", bus.rd_data_b, 32'hA5A5_001E);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    #1;
    check("byp_stored", bus.rd_data_a, 32'h0000_0040);
    check("byp_cnt", {16'h0, bus.wr_count}, 32'd32);
    exp_regs[31] = 32'h0000_0040;
    exp_cnt      = 16'd32;

    // Write-enable gating, also with an unknown address
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.wr_addr = 'x;
    @(posedge clk);
    #1;
    bus.wr_addr = 5'd0;
    bus.rd_addr_a = 5'd5;
    #1;
    check("gate_r5", bus.rd_data_a, 32'hA5A5_0005);
    check("gate_cnt", {16'h0, bus.wr_count}, 32'd32);
    check_all("gate");

    // Back-to-back writes to one register: last wins, both counted
    write_reg(5'd3, 32'h3333_0001);
    write_reg(5'd3, 32'h3333_0002);
    bus.rd_addr_b = 5'd3;
    #1;
    check("b2b_r3", bus.rd_data_b, 32'h3333_0002);
    check("b2b_cnt", {16'h0, bus.wr_count}, 32'd34);

    // Drive the counter to 16'hFFFF with a continuous write burst
    n = 32'hFFFF - 32'(exp_cnt);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd1;
    for (int k = 0; k < n; k++) begin
      bus.wr_data = 32'(k);
      @(posedge clk);
      #1;
    end
    bus.wr_en = 1'b0;
    exp_regs[1] = 32'(n - 1);
    bus.rd_addr_a = 5'd1;
    #1;
    check("pre_wrap_cnt", {16'h0, bus.wr_count}, 32'h0000_FFFF);
    check("burst_r1", bus.rd_data_a, exp_regs[1]);
    write_reg(5'd6, 32'h6666_6666);
    check("wrap_cnt", {16'h0, bus.wr_count}, 32'h0);
    bus.rd_addr_a = 5'd6;
    #1;
    check("wrap_r6", bus.rd_data_a, 32'h6666_6666);

    // Reset asserted while a write is pending: the write is lost
    @(negedge clk);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd7;
    bus.wr_data   = 32'hCAFE_F00D;
    bus.rd_addr_a = 5'd7;
    #1;
    check("pend_bypass", bus.rd_data_a, 32'hCAFE_F00D);
    #1;
    rst_n = 1'b0;
    #1;
    check("pend_rst_r7", bus.rd_data_a, 32'h0);
    bus.rd_addr_b = 5'd6;
    #1;
    check("pend_rst_r6", bus.rd_data_b, 32'h0);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    model_reset();
    check_all("mid_rst");
    check("mid_rst_cnt", {16'h0, bus.wr_count}, 32'h0);

    // First write lands on the first edge after deassertion
    @(negedge clk);
    rst_n       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 32'h2222_0002;
    @(posedge clk);
    #1;
    bus.wr_en     = 1'b0;
    bus.rd_addr_a = 5'd2;
    bus.rd_addr_b = 5'd29;
    #1;
    check("first_wr_r2", bus.rd_data_a, 32'h2222_0002);
    check("first_wr_sp", bus.rd_data_b, 32'h0000_0FFC);
    check("first_wr_cnt", {16'h0, bus.wr_count}, 32'd1);

    // Stack pointer is writable like any other register
    write_reg(5'd29, 32'h0000_0F00);
    #1;
    check("sp_write", bus.rd_data_b, 32'h0000_0F00);
    check("sp_cnt", {16'h0, bus.wr_count}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Architectural register file: 32 general-purpose 32-bit registers with two combinational read ports and one synchronous write port. Sits directly downstream of the 5-bit 3:1 destination-register mux, which selects rt, rd or the link register (31) and drives `wr_addr`. Writeback data comes from the result mux. Read ports feed the ALU operand path and the branch comparator.

## Interface
- `DATA_W`, default 32: register width.
- `SP_IDX`, default 29: index of the stack-pointer register.
- `SP_RESET`, default 32'h0000_0FFC: reset value of register `SP_IDX`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr_a`  in  5  read port A address (rs).
- `rd_addr_b`  in  5  read port B address (rt).
- `rd_data_a`  out  DATA_W  read port A data.
- `rd_data_b`  out  DATA_W  read port B data.
- `wr_en`  in  1  write enable (RegWrite from control).
- `wr_addr`  in  5  write address, from the destination-register mux.
- `wr_data`  in  DATA_W  writeback data.
- `wr_count`  out  16  committed-write counter; debug and performance.

## Operation
- Storage: 32 registers, r0..r31.
- r0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
  - Writes to address 0 do not increment `wr_count`.
- Reset (`rst_n`=0, asynchronous assert):
  - All registers clear to 0, except r`SP_IDX`, which loads `SP_RESET`.
  - `wr_count` clears to 0.
  - Reset overrides any write in progress.
  - Deassertion is sampled at the next rising edge; the first write can occur on the first edge with `rst_n`=1.
- Write: on a rising edge with `wr_en`=1 and `wr_addr`≠0, `reg[wr_addr]` takes `wr_data`, and `wr_count` increments by 1.
  - `wr_count` wraps from 16'hFFFF to 0.
- Read: `rd_data_x` = `reg[rd_addr_x]`, combinational, with write-through bypass.
  - If `wr_en`=1, `wr_addr`≠0 and `wr_addr`==`rd_addr_x`, then `rd_data_x` = `wr_data` in the same cycle.
  - This lets a single-cycle datapath read an in-flight result without a stall.
- Both ports may read the same address, including the write address. Each port bypasses independently.
- While `rst_n`=0, both read ports return the reset contents (0, or `SP_RESET` for r`SP_IDX`). The bypass is disabled during reset.
- Writes to r31 (link, via the jal path) and r`SP_IDX` behave like any other register; neither is write-protected.
- X on `wr_addr` while `wr_en`=0 must not corrupt state.

## Timing
- Write latency: 1 cycle. The value is visible from storage after the edge and via the bypass in the same cycle.
- Read latency: 0 cycles, combinational from address, storage and bypass inputs.
- Critical path: `wr_addr` compare → bypass mux → `rd_data`. It must be no worse than one 32:1 read mux plus one 2:1 mux.
- Simultaneous write and read of the same register in one cycle: the read returns the new data (bypass). After the edge, storage holds the same value.
- Back-to-back writes to the same address: the last write wins, and each write increments `wr_count`.
- Reset asserted mid-cycle: outputs switch to reset contents immediately, without waiting for `clk`.

## Test plan
- Reset value check:
  - Stimulus: pulse `rst_n` low mid-cycle, then read every address on both ports.
  - Required response: r29 reads 32'h0000_0FFC, all others read 0, `wr_count`=0.
- r0 protection:
  - Stimulus: write 32'hDEAD_BEEF to address 0, then read address 0.
  - Required response: read returns 0, `wr_count` unchanged.
- Write/read all registers:
  - Stimulus: write `32'hA5A5_0000 | i` to r1..r31, then read back on both ports.
  - Required response: each register returns its written value, `wr_count`=31.
- Bypass:
  - Stimulus: same cycle, `wr_en`=1, `wr_addr`=31 (jal path), `wr_data`=32'h0000_0040, `rd_addr_a`=`rd_addr_b`=31.
  - Required response: both ports read 32'h0000_0040 before the edge; r31 holds it after the edge.
- Write-enable gating:
  - Stimulus: `wr_en`=0, `wr_addr`=5, `wr_data`=32'h1234_5678.
  - Required response: r5 keeps its prior value, `wr_count` unchanged.
- Reset mid-operation and counter wrap:
  - Stimulus: preload `wr_count` to 16'hFFFF via 65535 writes, perform one more write, then assert `rst_n` while `wr_en`=1.
  - Required response: `wr_count` reads 0 after the wrap. After reset, the pending write is lost and registers hold reset values.
